rv_icache_direct: RTL and testbench

//  Read-only direct-mapped instruction cache between the pipelined core's instruction fetch port and main memory.
//  - Serves 32-bit word fetches from the core combinationally on a hit.
//  - On a miss, stalls the core and refills one 4-word block over a 128-bit memory handshake.
//  - Core write port is tied off; this block has no write path and no dirty state.

---
 rtl/rv_icache_direct.sv | 110 +++++++++++
 tb/tb_rv_icache_direct.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_icache_direct.sv
// Read-only direct-mapped instruction cache: combinational hit path, single
// outstanding 128-bit block refill on a miss.
module rv_icache_direct #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t                 state_reg;
    logic [NUM_BLOCKS-1:0]  valid_reg;
    logic [TAG_W-1:0]       tag_mem  [NUM_BLOCKS];
    logic [127:0]           data_mem [NUM_BLOCKS];
    logic [27:0]            miss_addr_reg;
    logic                   mem_read_reg;

    logic [INDEX_W-1:0]     idx;
    logic [TAG_W-1:0]       addr_tag;
    logic [INDEX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic [127:0]           line;
    logic [31:0]            line_words [4];
    logic                   hit;

    // The core has no write path into this cache; these inputs are accepted and dropped.
    logic unused_inputs;
    assign unused_inputs = ^{proc_write, proc_wdata};

    assign idx      = proc_addr[2 +: INDEX_W];
    assign addr_tag = proc_addr[29 -: TAG_W];
    assign miss_idx = miss_addr_reg[INDEX_W-1:0];
    assign miss_tag = miss_addr_reg[27 -: TAG_W];

    assign line = data_mem[idx];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign line_words[gi] = line[32*gi +: 32];
        end
    endgenerate

    assign hit        = proc_read & valid_reg[idx] & (tag_mem[idx] == addr_tag);
    assign proc_rdata = line_words[proc_addr[1:0]];
    assign proc_stall = proc_read & ~((state_reg == IDLE) & hit);

    assign mem_read  = mem_read_reg;
    assign mem_addr  = miss_addr_reg;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mem_read_reg  <= 1'b0;
            valid_reg     <= '0;
            miss_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (proc_read && !hit) begin
                        miss_addr_reg <= proc_addr[29:2];
                        mem_read_reg  <= 1'b1;
                        state_reg     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid_reg[miss_idx] <= 1'b1;
                        mem_read_reg        <= 1'b0;
                        state_reg           <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_read_reg <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; the fill is gated by rst_n so a reset
    // landing on the mem_ready edge leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst_n && state_reg == REFILL && mem_ready) begin
            data_mem[miss_idx] <= mem_rdata;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_rv_icache_direct.sv
// Scoreboard bench for rv_icache_direct: expected words are queued when a
// fetch is driven and compared when the cache releases the stall.
module tb_rv_icache_direct;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q [$];
    bit          m_valid [8];
    logic [27:0] m_blk   [8];

    rv_icache_direct #(.NUM_BLOCKS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: block 1 carries the 0x11111111.. pattern, others a hash.
    function automatic logic [31:0] word_of(input logic [27:0] blk, input logic [1:0] k);
        logic [31:0] mult;
        mult = 32'(k) + 32'd1;
        if (blk == 28'h1) return 32'h11111111 * mult;
        return {blk[15:0] ^ 16'hBEEF, 6'h2A, k, 8'h96};
    endfunction

    function automatic logic [127:0] block_of(input logic [27:0] blk);
        return {word_of(blk, 2'd3), word_of(blk, 2'd2), word_of(blk, 2'd1), word_of(blk, 2'd0)};
    endfunction

    task automatic fetch(input logic [29:0] a, input int lat);
        logic [27:0] blk;
        int          idx;
        bit          hit;
        blk = a[29:2];
        idx = int'(blk[2:0]);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
        hit = m_valid[idx] && (m_blk[idx] == blk);
        sb_q.push_back(word_of(blk, a[1:0]));
        if (!hit) begin
            check("miss_stall", proc_stall, 1);
            step();
            check("mem_read_up", mem_read, 1);
            check("mem_addr", mem_addr, blk);
            for (int i = 1; i < lat; i++) begin
                step();
                check("refill_hold", mem_read, 1);
                check("refill_stall", proc_stall, 1);
            end
            mem_rdata = block_of(blk);
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            check("mem_read_drop", mem_read, 0);
            check("stall_after_refill", proc_stall, 0);
            m_valid[idx] = 1'b1;
            m_blk[idx]   = blk;
        end else begin
            check("hit_stall", proc_stall, 0);
            check("hit_mem_read", mem_read, 0);
        end
        for (int i = 0; i < 4 && proc_stall; i++) step();
        if (proc_stall) begin
            check("stall_timeout", 1, 0);
            void'(sb_q.pop_front());
        end else begin
            check("rdata", proc_rdata, sb_q.pop_front());
        end
        check("mem_write", mem_write, 0);
        $display("fetch addr=%08h %s rdata=%08h", a, hit ? "hit " : "miss", proc_rdata);
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h4;
        proc_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_blk[i]   = '0;
        end
        step();
        step();
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cold_stall", proc_stall, 1);
        $display("reset applied, stall=%0b mem_read=%0b", proc_stall, mem_read);
        rst_n = 1'b1;

        // Cold miss on block 1 with a three-cycle memory, then its other words hit.
        fetch(30'h4, 3);
        fetch(30'h5, 1);
        fetch(30'h6, 1);
        fetch(30'h7, 1);

        // Conflict on index 0: block 0 and block 8 evict each other.
        fetch(30'h0, 2);
        fetch(30'h20, 2);
        fetch(30'h3, 1);
        fetch(30'h21, 1);

        // Write-side inputs with no read request.
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_wdata = 32'hDEADBEEF;
        proc_addr  = 30'h5;
        #1;
        check("wr_stall", proc_stall, 0);
        check("wr_mem_read", mem_read, 0);
        check("wr_mem_write", mem_write, 0);
        step();
        check("wr_mem_read_next", mem_read, 0);
        $display("write request ignored, stall=%0b mem_write=%0b", proc_stall, mem_write);
        proc_write = 1'b0;
        fetch(30'h5, 1);

        // Stray mem_ready while idle must not touch any line.
        proc_read = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("idle_ready_mem_read", mem_read, 0);
        $display("idle mem_ready pulse with data %032h", mem_rdata);
        fetch(30'h4, 1);
        fetch(30'h7, 1);
        fetch(30'h21, 1);

        // Reset two cycles into a refill, then a late mem_ready.
        proc_read = 1'b1;
        proc_addr = 30'h13;
        #1;
        step();
        check("rr_mem_read_up", mem_read, 1);
        step();
        rst_n = 1'b0;
        step();
        check("rr_mem_read_cleared", mem_read, 0);
        check("rr_mem_addr_cleared", mem_addr, 0);
        proc_read = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        step();
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("late_ready_mem_read", mem_read, 0);
        check("late_ready_stall", proc_stall, 0);
        $display("reset during refill, late mem_ready ignored");
        fetch(30'h13, 2);
        fetch(30'h4, 1);

        // Highest index line.
        fetch(30'h1D, 2);
        fetch(30'h1F, 1);
        fetch(30'h3E, 1);
        fetch(30'h1C, 1);

        check("scoreboard_empty", 128'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
